// File: rtl/memory_stage_if.sv
// Shared types for the memory stage and the request/acknowledge data bus interface
// between the stage (master) and the memory system (slave).
package memory_stage_pkg;
  typedef logic [2:0]  csrOp_;
  typedef logic [11:0] destinationCSR_;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  typedef struct packed {
    logic           valid;
    logic           illegal;
    logic [4:0]     destinationRegister;
    logic           writebackEnable;
    logic [31:0]    data;
    csrOp_          CSROp;
    destinationCSR_ destinationCSR;
    logic           CSRWriteIntent;
    logic [31:0]    oldCSRValue;
  } memoryWritebackPayload_;
endpackage

interface memory_stage_if;
  logic        dataRequest;
  logic        dataWrite;
  logic [31:0] dataAddress;
  logic [31:0] dataWriteData;
  logic [3:0]  dataByteEnable;
  logic        dataAck;
  logic [31:0] dataReadData;

  modport master (
    output dataRequest, dataWrite, dataAddress, dataWriteData, dataByteEnable,
    input  dataAck, dataReadData
  );
  modport slave (
    input  dataRequest, dataWrite, dataAddress, dataWriteData, dataByteEnable,
    output dataAck, dataReadData
  );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: registers the execute result and performs loads/stores
// over a request/acknowledge bus, stalling upstream while an access is open.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter bit RESET_HOLD_BUS = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   inValid,
  input  logic                   inIllegal,
  input  logic [4:0]             inDest,
  input  logic                   inWritebackEnable,
  input  logic [31:0]            inData,
  input  logic [31:0]            inStoreData,
  input  logic [3:0]             inMemOp,
  input  csrOp_                  inCSROp,
  input  destinationCSR_         inDestCSR,
  input  logic                   inCSRWriteIntent,
  input  logic [31:0]            inOldCSRValue,
  output logic                   stall,
  memory_stage_if.master         bus,
  output memoryWritebackPayload_ memoryWritebackPayload
);
  typedef enum logic {IDLE, BUS} state_t;
  state_t state_reg;

  logic           request_reg;
  logic           write_reg;
  logic [31:0]    address_reg;
  logic [31:0]    wdata_reg;
  logic [3:0]     be_reg;
  logic [3:0]     op_reg;
  logic [1:0]     offset_reg;
  logic [4:0]     dest_reg;
  logic           we_reg;
  logic [31:0]    data_reg;
  csrOp_          csr_op_reg;
  destinationCSR_ dest_csr_reg;
  logic           csr_wi_reg;
  logic [31:0]    old_csr_reg;
  logic           flush_sticky_reg;
  memoryWritebackPayload_ payload_reg;

  logic        is_byte, is_half, is_word, is_mem, is_store, misaligned, take_bus;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] read_shifted, load_data;
  memoryWritebackPayload_ pass_payload, bus_payload;

  always_comb begin
    is_byte    = (inMemOp == MEM_LB) || (inMemOp == MEM_LBU) || (inMemOp == MEM_SB);
    is_half    = (inMemOp == MEM_LH) || (inMemOp == MEM_LHU) || (inMemOp == MEM_SH);
    is_word    = (inMemOp == MEM_LW) || (inMemOp == MEM_SW);
    is_mem     = is_byte || is_half || is_word;
    is_store   = (inMemOp == MEM_SB) || (inMemOp == MEM_SH) || (inMemOp == MEM_SW);
    misaligned = (is_half && inData[0]) || (is_word && (inData[1:0] != 2'b00));
    take_bus   = (state_reg == IDLE) && inValid && !flush && is_mem && !inIllegal && !misaligned;
    if (is_byte)      be_next = 4'b0001 << inData[1:0];
    else if (is_half) be_next = 4'b0011 << inData[1:0];
    else              be_next = 4'b1111;
  end

  // Store data is replicated so every candidate lane carries the right bytes.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_next[8*gi +: 8] = !is_store ? 8'h00 :
                                   is_byte   ? inStoreData[7:0] :
                                   is_half   ? inStoreData[8*(gi%2) +: 8] :
                                               inStoreData[8*gi +: 8];
  end

  assign read_shifted = bus.dataReadData >> {offset_reg, 3'b000};

  always_comb begin
    case (op_reg)
      MEM_LB:  load_data = {{24{read_shifted[7]}}, read_shifted[7:0]};
      MEM_LH:  load_data = {{16{read_shifted[15]}}, read_shifted[15:0]};
      MEM_LBU: load_data = {24'h000000, read_shifted[7:0]};
      MEM_LHU: load_data = {16'h0000, read_shifted[15:0]};
      default: load_data = bus.dataReadData;
    endcase
  end

  always_comb begin
    pass_payload                     = '0;
    pass_payload.valid               = 1'b1;
    pass_payload.illegal             = inIllegal | (is_mem & misaligned);
    pass_payload.destinationRegister = inDest;
    pass_payload.writebackEnable     = (is_mem && !inIllegal && misaligned) ? 1'b0 : inWritebackEnable;
    pass_payload.data                = inData;
    pass_payload.CSROp               = inCSROp;
    pass_payload.destinationCSR      = inDestCSR;
    pass_payload.CSRWriteIntent      = inCSRWriteIntent;
    pass_payload.oldCSRValue         = inOldCSRValue;

    bus_payload                      = '0;
    bus_payload.valid                = 1'b1;
    bus_payload.destinationRegister  = dest_reg;
    bus_payload.writebackEnable      = write_reg ? 1'b0 : we_reg;
    bus_payload.data                 = write_reg ? data_reg : load_data;
    bus_payload.CSROp                = csr_op_reg;
    bus_payload.destinationCSR       = dest_csr_reg;
    bus_payload.CSRWriteIntent       = csr_wi_reg;
    bus_payload.oldCSRValue          = old_csr_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      request_reg      <= 1'b0;
      write_reg        <= 1'b0;
      address_reg      <= '0;
      wdata_reg        <= '0;
      be_reg           <= '0;
      op_reg           <= MEM_NONE;
      offset_reg       <= '0;
      dest_reg         <= '0;
      we_reg           <= 1'b0;
      data_reg         <= '0;
      csr_op_reg       <= '0;
      dest_csr_reg     <= '0;
      csr_wi_reg       <= 1'b0;
      old_csr_reg      <= '0;
      flush_sticky_reg <= 1'b0;
      payload_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          payload_reg <= '0;
          if (take_bus) begin
            state_reg        <= BUS;
            request_reg      <= 1'b1;
            write_reg        <= is_store;
            address_reg      <= {inData[31:2], 2'b00};
            wdata_reg        <= wdata_next;
            be_reg           <= be_next;
            op_reg           <= inMemOp;
            offset_reg       <= inData[1:0];
            dest_reg         <= inDest;
            we_reg           <= inWritebackEnable;
            data_reg         <= inData;
            csr_op_reg       <= inCSROp;
            dest_csr_reg     <= inDestCSR;
            csr_wi_reg       <= inCSRWriteIntent;
            old_csr_reg      <= inOldCSRValue;
            flush_sticky_reg <= 1'b0;
          end else if (inValid && !flush) begin
            payload_reg <= pass_payload;
          end
        end
        BUS: begin
          payload_reg <= '0;
          // A flushed access still runs to completion; only its result is dropped.
          if (bus.dataAck) begin
            state_reg        <= IDLE;
            request_reg      <= 1'b0;
            write_reg        <= 1'b0;
            address_reg      <= '0;
            wdata_reg        <= '0;
            be_reg           <= '0;
            flush_sticky_reg <= 1'b0;
            if (!(flush || flush_sticky_reg)) payload_reg <= bus_payload;
          end else if (flush) begin
            flush_sticky_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stall                  = (state_reg == BUS) || take_bus;
  assign bus.dataRequest        = request_reg & ~(RESET_HOLD_BUS & reset);
  assign bus.dataWrite          = write_reg;
  assign bus.dataAddress        = address_reg;
  assign bus.dataWriteData      = wdata_reg;
  assign bus.dataByteEnable     = be_reg;
  assign memoryWritebackPayload = payload_reg;
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a driver issues random and directed
// instructions, a negedge checker acts as bus slave and compares all outputs.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0, inValid = 1'b0, inIllegal = 1'b0;
  logic [4:0] inDest = '0;
  logic inWritebackEnable = 1'b0;
  logic [31:0] inData = '0, inStoreData = '0;
  logic [3:0] inMemOp = '0;
  csrOp_ inCSROp = '0;
  destinationCSR_ inDestCSR = '0;
  logic inCSRWriteIntent = 1'b0;
  logic [31:0] inOldCSRValue = '0;
  logic stall;
  memoryWritebackPayload_ payload;

  memory_stage_if bus_if();

  memory_stage #(.RESET_HOLD_BUS(1'b1)) dut (
    .clock(clock), .reset(reset), .flush(flush), .inValid(inValid), .inIllegal(inIllegal),
    .inDest(inDest), .inWritebackEnable(inWritebackEnable), .inData(inData),
    .inStoreData(inStoreData), .inMemOp(inMemOp), .inCSROp(inCSROp), .inDestCSR(inDestCSR),
    .inCSRWriteIntent(inCSRWriteIntent), .inOldCSRValue(inOldCSRValue), .stall(stall),
    .bus(bus_if), .memoryWritebackPayload(payload)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  typedef struct {
    memoryWritebackPayload_ p;
    bit check_data;
    int at_cycle;
  } exp_t;
  exp_t exp_q[$];

  // Driver-owned expectations read by the checker.
  bit          stall_en = 1'b0, exp_stall = 1'b0, exp_bus_active = 1'b0, done = 1'b0;
  bit          exp_bus_write = 1'b0;
  logic [31:0] exp_bus_addr = '0, exp_bus_wdata = '0, rd_word = '0;
  logic [3:0]  exp_bus_be = '0;
  int          ack_delay = 0;

  // Checker-owned state.
  int checks = 0, errors = 0, req_cycles = 0, txn = 0;
  bit last_neg_reset = 1'b0, finished = 1'b0;

  function automatic int msize(input logic [3:0] op);
    if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 1;
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
    if (op == MEM_LW || op == MEM_SW) return 4;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, expv);
    end
  endtask

  // Checker, bus slave and payload monitor.
  initial begin
    bus_if.dataAck = 1'b0;
    bus_if.dataReadData = '0;
    forever begin
      @(negedge clock);
      if (last_neg_reset) begin
        chk("rst_payload_nonzero", {31'b0, payload != '0}, 32'd0);
        chk("rst_request", {31'b0, bus_if.dataRequest}, 32'd0);
        chk("rst_write", {31'b0, bus_if.dataWrite}, 32'd0);
        chk("rst_be", {28'b0, bus_if.dataByteEnable}, 32'd0);
        chk("rst_addr", bus_if.dataAddress, 32'd0);
        chk("rst_wdata", bus_if.dataWriteData, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
      end
      if (reset) chk("request_in_reset", {31'b0, bus_if.dataRequest}, 32'd0);
      else begin
        if (stall_en) chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        chk("request", {31'b0, bus_if.dataRequest}, {31'b0, exp_bus_active});
      end
      if (bus_if.dataRequest && exp_bus_active) begin
        chk("bus_addr", bus_if.dataAddress, exp_bus_addr);
        chk("bus_be", {28'b0, bus_if.dataByteEnable}, {28'b0, exp_bus_be});
        chk("bus_wdata", bus_if.dataWriteData, exp_bus_wdata);
        chk("bus_write", {31'b0, bus_if.dataWrite}, {31'b0, exp_bus_write});
      end
      if (payload.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_payload", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d cycle %0d dest %0d illegal %0d we %0d data %h", txn, cycle,
                   payload.destinationRegister, payload.illegal, payload.writebackEnable, payload.data);
          chk("latency_cycle", cycle, e.at_cycle);
          chk("illegal", {31'b0, payload.illegal}, {31'b0, e.p.illegal});
          chk("dest", {27'b0, payload.destinationRegister}, {27'b0, e.p.destinationRegister});
          chk("wb_enable", {31'b0, payload.writebackEnable}, {31'b0, e.p.writebackEnable});
          if (e.check_data) chk("data", payload.data, e.p.data);
          chk("csr_op", {29'b0, payload.CSROp}, {29'b0, e.p.CSROp});
          chk("dest_csr", {20'b0, payload.destinationCSR}, {20'b0, e.p.destinationCSR});
          chk("csr_wi", {31'b0, payload.CSRWriteIntent}, {31'b0, e.p.CSRWriteIntent});
          chk("old_csr", payload.oldCSRValue, e.p.oldCSRValue);
        end
      end
      if (bus_if.dataRequest === 1'b1) begin
        bus_if.dataAck = (req_cycles == ack_delay);
        bus_if.dataReadData = (req_cycles == ack_delay) ? rd_word : $urandom;
        req_cycles++;
      end else begin
        bus_if.dataAck = 1'b0;
        req_cycles = 0;
      end
      last_neg_reset = reset;
      if (done && !finished) begin
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        finished = 1'b1;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      inValid = 1'b0; flush = 1'b0; exp_stall = 1'b0; exp_bus_active = 1'b0;
    end
  endtask

  // fmode: 0 none, 1 flush in the issue cycle, 2 flush in bus cycle fi.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rd, input bit ill, input bit we, input logic [4:0] dest,
                       input int d, input int fmode, input int fi);
    int sz, off;
    bit mem, mis, store, sgn, go_bus;
    logic [31:0] mask, lane;
    exp_t e;
    @(posedge clock); #1;
    inValid = 1'b1; inMemOp = op; inData = addr; inStoreData = sd; inIllegal = ill;
    inWritebackEnable = we; inDest = dest; inCSROp = 3'($urandom); inDestCSR = 12'($urandom);
    inCSRWriteIntent = 1'($urandom); inOldCSRValue = $urandom;
    flush = (fmode == 1);
    ack_delay = d; rd_word = rd;
    sz = msize(op); mem = (sz != 0); off = int'(addr[1:0]);
    mis = mem && ((off % sz) != 0);
    store = (op == MEM_SB || op == MEM_SH || op == MEM_SW);
    sgn = (op == MEM_LB || op == MEM_LH);
    go_bus = mem && !ill && !mis && (fmode != 1);
    exp_stall = go_bus; exp_bus_active = 1'b0; stall_en = 1'b1;
    e.p = '0;
    e.p.valid = 1'b1; e.p.destinationRegister = dest; e.p.CSROp = inCSROp;
    e.p.destinationCSR = inDestCSR; e.p.CSRWriteIntent = inCSRWriteIntent;
    e.p.oldCSRValue = inOldCSRValue;
    if (!go_bus) begin
      if (fmode != 1) begin
        e.p.illegal = ill || mis;
        e.p.writebackEnable = (mem && !ill && mis) ? 1'b0 : we;
        e.p.data = addr;
        e.check_data = !(mem && !ill && mis);
        e.at_cycle = cycle + 1;
        exp_q.push_back(e);
      end
    end else begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      lane = (rd >> (8 * off)) & mask;
      if (sgn && lane[8*sz-1]) lane = lane | ~mask;
      exp_bus_addr = addr & 32'hFFFF_FFFC;
      exp_bus_be = 4'(((1 << sz) - 1) << off);
      exp_bus_write = store;
      exp_bus_wdata = !store ? 32'd0 : (sz == 1) ? sd[7:0] * 32'h0101_0101 :
                      (sz == 2) ? sd[15:0] * 32'h0001_0001 : sd;
      e.p.illegal = 1'b0;
      e.p.writebackEnable = store ? 1'b0 : we;
      e.p.data = lane;
      e.check_data = !store;
      e.at_cycle = cycle + 2 + d;
      if (fmode != 2) exp_q.push_back(e);
      for (int i = 0; i <= d; i++) begin
        @(posedge clock); #1;
        inValid = 1'b0;
        flush = (fmode == 2) && (i == fi);
        exp_stall = 1'b1; exp_bus_active = 1'b1;
      end
    end
  endtask

  task automatic reset_mid_bus();
    @(posedge clock); #1;
    inValid = 1'b1; inMemOp = MEM_LW; inData = 32'h0000_5000; inIllegal = 1'b0; flush = 1'b0;
    inWritebackEnable = 1'b1; inDest = 5'd9;
    ack_delay = 50;
    exp_stall = 1'b1; exp_bus_active = 1'b0; stall_en = 1'b1;
    exp_bus_addr = 32'h0000_5000; exp_bus_be = 4'b1111; exp_bus_write = 1'b0; exp_bus_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      inValid = 1'b0; exp_stall = 1'b1; exp_bus_active = 1'b1;
    end
    @(posedge clock); #1;
    reset = 1'b1; stall_en = 1'b0; exp_bus_active = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; stall_en = 1'b1; exp_stall = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    logic [31:0] addr;
    int d, fmode, sz;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; stall_en = 1'b1;
    idle(1);
    issue(MEM_NONE, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 0, 0, 0);
    issue(MEM_LB,   32'h0000_1003, 32'h0, 32'h80AA_BBCC, 1'b0, 1'b1, 5'd6, 2, 0, 0);
    issue(MEM_LHU,  32'h0000_2002, 32'h0, 32'hBEEF_1234, 1'b0, 1'b1, 5'd7, 0, 0, 0);
    issue(MEM_SH,   32'h0000_3002, 32'h0000_CAFE, 32'h0, 1'b0, 1'b1, 5'd8, 1, 0, 0);
    issue(MEM_LW,   32'h0000_4001, 32'h0, 32'h0, 1'b0, 1'b1, 5'd10, 0, 0, 0);
    issue(MEM_LW,   32'h0000_4000, 32'h0, 32'h1111_2222, 1'b0, 1'b1, 5'd11, 3, 2, 1);
    issue(MEM_LW,   32'h0000_4004, 32'h0, 32'h3333_4444, 1'b0, 1'b1, 5'd12, 1, 2, 1);
    issue(MEM_SW,   32'h0000_4008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 5'd13, 0, 1, 0);
    issue(MEM_LB,   32'h0000_4009, 32'h0, 32'h0, 1'b1, 1'b1, 5'd14, 0, 0, 0);
    idle(1);
    reset_mid_bus();
    idle(1);
    for (int n = 0; n < 250; n++) begin
      op = 4'($urandom_range(0, 8));
      addr = $urandom;
      sz = msize(op);
      if (sz != 0 && $urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
      d = $urandom_range(0, 3);
      fmode = ($urandom_range(0, 9) == 0) ? 1 : ($urandom_range(0, 5) == 0) ? 2 : 0;
      issue(op, addr, $urandom, $urandom, ($urandom_range(0, 9) == 0), 1'($urandom),
            5'($urandom), d, fmode, $urandom_range(0, d));
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(3);
    done = 1'b1;
    wait (finished);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
